// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding host command to APB master, paced by a free-running pclken divider
module apb_master_bridge #(
  parameter int ADDR_BITS = 16,
  parameter int CLK_DIV   = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [31:0]          cmd_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic                 pclken,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [ADDR_BITS-1:0] paddr,
  output logic [31:0]          pwdata,
  input  logic [31:0]          prdata,
  input  logic                 pslverr,
  input  logic                 pready
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [7:0] tocnt;
  logic rdy_q, pend, h_write, to_hit;
  logic [ADDR_BITS-1:0] h_addr;
  logic [31:0] h_wdata;
  assign pclken = cnt == CW'(CLK_DIV - 1);
  assign cmd_ready = rdy_q & (state == IDLE) & ~pend;
  assign to_hit = tocnt == 8'(TIMEOUT - 1);
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:   state_d = pclken && pend ? SETUP : IDLE;
      SETUP:  state_d = pclken ? ACCESS : SETUP;
      ACCESS: state_d = pclken && (pready || to_hit) ? RESP : ACCESS;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      tocnt <= '0;
      rdy_q <= 1'b0;
      pend <= 1'b0;
      h_write <= 1'b0;
      h_addr <= '0;
      h_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      rsp_timeout <= 1'b0;
      psel <= 1'b0;
      penable <= 1'b0;
      pwrite <= 1'b0;
      paddr <= '0;
      pwdata <= '0;
    end else begin
      cnt <= pclken ? '0 : cnt + CW'(1);
      rdy_q <= 1'b1;
      rsp_valid <= state == RESP;
      if (cmd_valid && cmd_ready) begin
        pend <= 1'b1;
        h_write <= cmd_write;
        h_addr <= cmd_addr;
        h_wdata <= cmd_wdata;
      end
      if (pclken) begin
        if (state == IDLE && pend) begin
          pend <= 1'b0;
          psel <= 1'b1;
          penable <= 1'b0;
          pwrite <= h_write;
          paddr <= h_addr;
          pwdata <= h_wdata;
        end
        if (state == SETUP) begin
          penable <= 1'b1;
          tocnt <= '0;
        end
        // pready wins over a coincident timeout
        if (state == ACCESS) begin
          if (pready || to_hit) begin
            psel <= 1'b0;
            penable <= 1'b0;
            rsp_rdata <= pready && !pwrite ? prdata : 32'h0;
            rsp_err <= pready ? pslverr : 1'b1;
            rsp_timeout <= !pready;
          end else begin
            tocnt <= tocnt + 8'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed commands against a small regfile model; scoreboard monitor checks responses
module tb_apb_master_bridge;
  logic clk = 0, reset_n = 0;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [15:0] cmd_addr = 0;
  logic [31:0] cmd_wdata = 0;
  logic rsp_valid, rsp_err, rsp_timeout, pclken, psel, penable, pwrite;
  logic [31:0] rsp_rdata, pwdata, prdata;
  logic [15:0] paddr;
  logic pslverr, pready, stall = 0;
  logic [31:0] r0 = 0, r4 = 0;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {logic [31:0] rdata; logic err; logic to; int acc; int lo; int hi;} exp_t;
  exp_t q[$];

  apb_master_bridge #(.ADDR_BITS(16), .CLK_DIV(2), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .pclken(pclken), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pslverr(pslverr), .pready(pready));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // regfile model: 0x0/0x4 RW, 0x8 RO = 0x1234, everything else unmapped
  always_comb begin
    pready = ~stall;
    pslverr = 1'b0;
    prdata = 32'h0;
    case (paddr)
      16'h0000: prdata = r0;
      16'h0004: prdata = r4;
      16'h0008: begin prdata = 32'h1234; pslverr = pwrite; end
      default:  pslverr = 1'b1;
    endcase
  end
  always @(posedge clk)
    if (pclken && psel && penable && pready && pwrite && !pslverr) begin
      if (paddr == 16'h0000) r0 <= pwdata;
      if (paddr == 16'h0004) r4 <= pwdata;
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic w, input logic [15:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic ee, input logic et, input int lo, input int hi);
    int n = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'(n), 32'd0);
      cmd_valid = 0;
    end else begin
      @(posedge clk); #1;
      q.push_back('{er, ee, et, cyc, lo, hi});
    end
  endtask

  task automatic drain();
    int n = 0;
    cmd_valid = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  logic p_pclk = 0, p_rst = 0;
  logic [50:0] p_apb = 0;
  wire [50:0] apb = {psel, penable, pwrite, paddr, pwdata};
  always @(negedge clk) begin
    exp_t e;
    int lat;
    if (reset_n && rsp_valid) begin
      if (q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        lat = cyc - e.acc;
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
        chk("psel_after_rsp", 32'(psel), 32'd0);
        total++;
        if (lat < e.lo || lat > e.hi) begin
          bad++;
          $display("FAIL latency: got %0d expected %0d..%0d", lat, e.lo, e.hi);
        end
      end
    end
    if (reset_n && psel) chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    if (reset_n && p_rst && apb != p_apb) chk("apb_change_on_tick", 32'(p_pclk), 32'd1);
    p_pclk <= pclken;
    p_rst <= reset_n;
    p_apb <= apb;
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_pclken", 32'(pclken), 32'd0);
    chk("rst_rsp", {rsp_rdata[29:0], rsp_err, rsp_timeout}, 32'd0);
    reset_n = 1;
    chk("ready_before_clk", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready_after_clk", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    // zero-wait transfer: 1..2 clk to first tick, then 2+2 clk, then 1 clk response
    send(1, 16'h0004, 32'hA5A5_0001, 32'h0, 0, 0, 6, 7); drain();
    send(0, 16'h0004, 32'h0, 32'hA5A5_0001, 0, 0, 6, 7); drain();
    send(0, 16'h0008, 32'h0, 32'h0000_1234, 0, 0, 6, 7); drain();
    send(1, 16'h0008, 32'hFFFF_FFFF, 32'h0, 1, 0, 6, 7); drain();
    send(0, 16'h0040, 32'h0, 32'h0, 1, 0, 6, 7); drain();
    chk("ro_unchanged", r4, 32'hA5A5_0001);
    // timeout: 8 ACCESS ticks of 2 clk each after SETUP
    stall = 1;
    send(0, 16'h0004, 32'h0, 32'h0, 1, 1, 20, 21); drain();
    stall = 0;
    send(0, 16'h0004, 32'h0, 32'hA5A5_0001, 0, 0, 6, 7); drain();
    // cmd_valid held across three commands
    @(negedge clk);
    send(1, 16'h0000, 32'h11, 32'h0, 0, 0, 6, 7);
    send(1, 16'h0004, 32'h22, 32'h0, 0, 0, 6, 7);
    send(0, 16'h0000, 32'h0, 32'h11, 0, 0, 6, 7);
    drain();
    chk("b2b_r4", r4, 32'h22);
    // reset during ACCESS
    stall = 1;
    @(negedge clk);
    send(0, 16'h0004, 32'h0, 32'h0, 0, 0, 0, 0);
    cmd_valid = 0;
    for (int n = 0; n < 50 && !penable; n++) @(negedge clk);
    chk("reached_access", 32'(penable), 32'd1);
    repeat (3) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_psel", 32'(psel), 32'd0);
    chk("mid_rst_penable", 32'(penable), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    q.delete();
    stall = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    chk("restart_pclken0", 32'(pclken), 32'd0);
    @(posedge clk); #1;
    chk("restart_pclken1", 32'(pclken), 32'd1);
    chk("restart_ready", 32'(cmd_ready), 32'd1);
    repeat (30) @(negedge clk);
    send(0, 16'h0004, 32'h0, 32'h22, 0, 0, 6, 7); drain();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
